// File: rtl/dm_pkg.sv
// Shared types and constants for the 16-bit data memory responder.
package dm_pkg;

  // Width of the wait-state down-counter (supports 0..7 hold cycles).
  localparam int WAIT_CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dm_state_e;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } dm_acc_e;

  // Decode the active-low bus strobes into an access type.
  // Write enable wins over output enable; CE high means no access.
  function automatic dm_acc_e decode_access(input logic ce_n,
                                            input logic oe_n,
                                            input logic we_n);
    dm_acc_e acc;
    if (ce_n) begin
      acc = ACC_NONE;
    end else if (!we_n) begin
      acc = ACC_WRITE;
    end else if (!oe_n) begin
      acc = ACC_READ;
    end else begin
      acc = ACC_NONE;
    end
    return acc;
  endfunction

endpackage

// File: rtl/dm_ram_array.sv
// Single-port synchronous RAM with a registered, read-enabled output port.
// Addresses at or above DEPTH never touch the array and read back as zero.
module dm_ram_array #(
  parameter int MSB_DATA = 16,
  parameter int MSB_ROM  = 11,
  parameter int DEPTH    = 2048
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [MSB_ROM-1:0]  addr,
  input  logic [MSB_DATA-1:0] wdata,
  output logic [MSB_DATA-1:0] rdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MSB_ROM:0] DEPTH_W = (MSB_ROM+1)'(DEPTH);

  logic [MSB_DATA-1:0] mem_r [0:DEPTH-1];
  logic                in_range_s;

  assign in_range_s = ({1'b0, addr} < DEPTH_W);

  // Array write port: only in-range addresses are stored.
  always_ff @(posedge clk) begin
    if (we && in_range_s) begin
      mem_r[addr[AW-1:0]] <= wdata;
    end
  end

  // Registered read port: updates only when a read is requested, so the
  // value is held across writes and idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= {MSB_DATA{1'b0}};
    end else if (re) begin
      rdata <= in_range_s ? mem_r[addr[AW-1:0]] : {MSB_DATA{1'b0}};
    end
  end

endmodule

// File: rtl/data_memory_16bits.sv
// Data memory responder for the processor's active-low memory bus.
// Samples requests in IDLE, freezes the processor through HOLD_n_o for
// WAIT_STATES cycles, then commits the access to the RAM array.
module data_memory_16bits #(
  parameter int MSB_DATA    = 16,
  parameter int MSB_ROM     = 11,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 1,
  parameter int LSB         = 0
) (
  input  logic                CLOCK_i,
  input  logic                RESET_i,
  input  logic                CEnable_dm_i,
  input  logic                OEnable_dm_i,
  input  logic                WEnable_dm_i,
  input  logic [MSB_ROM-1:0]  ADDR_dm_i,
  input  logic [MSB_DATA-1:0] DATA_dm_i,
  output logic [MSB_DATA-1:0] DATA_dm_o,
  output logic                HOLD_n_o,
  output logic                ERROR_o
);

  import dm_pkg::*;

  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_wait_states
    $error("data_memory_16bits: WAIT_STATES must be within 0..7");
  end
  if (DEPTH < 2 || DEPTH > (2 ** MSB_ROM)) begin : g_bad_depth
    $error("data_memory_16bits: DEPTH must be within 2..2**MSB_ROM");
  end
  if (LSB != 0) begin : g_bad_lsb
    $error("data_memory_16bits: only LSB = 0 is supported");
  end

  localparam bit NO_WAIT = (WAIT_STATES == 0);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  localparam logic [MSB_ROM:0] DEPTH_W = (MSB_ROM+1)'(DEPTH);

  dm_state_e             state_r;
  logic [WAIT_CNT_W-1:0] cnt_r;
  dm_acc_e               req_acc_r;
  logic [MSB_ROM-1:0]    req_addr_r;
  logic [MSB_DATA-1:0]   req_data_r;
  logic                  hold_n_r;
  logic                  error_r;

  dm_acc_e               sample_acc_s;
  logic                  illegal_s;
  dm_acc_e               commit_acc_s;
  logic [MSB_ROM-1:0]    commit_addr_s;
  logic [MSB_DATA-1:0]   commit_data_s;
  logic                  in_range_s;
  logic                  ram_we_s;
  logic                  ram_re_s;

  // Request decode: the bus is only looked at while idle.
  always_comb begin
    sample_acc_s = ACC_NONE;
    illegal_s    = 1'b0;
    if (state_r == IDLE) begin
      sample_acc_s = decode_access(CEnable_dm_i, OEnable_dm_i, WEnable_dm_i);
      illegal_s    = !CEnable_dm_i && !OEnable_dm_i && !WEnable_dm_i;
    end else begin
      sample_acc_s = ACC_NONE;
      illegal_s    = 1'b0;
    end
  end

  // Commit selection: zero-wait accesses commit straight from the bus at the
  // sampling edge, otherwise from the captured request on the last wait cycle.
  always_comb begin
    commit_acc_s  = ACC_NONE;
    commit_addr_s = req_addr_r;
    commit_data_s = req_data_r;
    case (state_r)
      IDLE: begin
        if (NO_WAIT) begin
          commit_acc_s  = sample_acc_s;
          commit_addr_s = ADDR_dm_i;
          commit_data_s = DATA_dm_i;
        end else begin
          commit_acc_s  = ACC_NONE;
        end
      end
      WAIT: begin
        if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
          commit_acc_s = req_acc_r;
        end else begin
          commit_acc_s = ACC_NONE;
        end
      end
      default: commit_acc_s = ACC_NONE;
    endcase
  end

  assign in_range_s = ({1'b0, commit_addr_s} < DEPTH_W);
  assign ram_we_s   = !RESET_i && (commit_acc_s == ACC_WRITE) && in_range_s;
  assign ram_re_s   = !RESET_i && (commit_acc_s == ACC_READ);

  // Wait-state FSM, request capture, hold output and sticky error flag.
  always_ff @(posedge CLOCK_i) begin
    if (RESET_i) begin
      state_r    <= IDLE;
      cnt_r      <= {WAIT_CNT_W{1'b0}};
      req_acc_r  <= ACC_NONE;
      req_addr_r <= {MSB_ROM{1'b0}};
      req_data_r <= {MSB_DATA{1'b0}};
      hold_n_r   <= 1'b1;
      error_r    <= 1'b0;
    end else begin
      if (illegal_s || ((commit_acc_s != ACC_NONE) && !in_range_s)) begin
        error_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (sample_acc_s != ACC_NONE) begin
            req_acc_r  <= sample_acc_s;
            req_addr_r <= ADDR_dm_i;
            req_data_r <= DATA_dm_i;
            if (!NO_WAIT) begin
              state_r  <= WAIT;
              cnt_r    <= WAIT_LOAD;
              hold_n_r <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
            state_r   <= IDLE;
            hold_n_r  <= 1'b1;
            req_acc_r <= ACC_NONE;
          end else begin
            cnt_r <= cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r  <= IDLE;
          hold_n_r <= 1'b1;
        end
      endcase
    end
  end

  dm_ram_array #(
    .MSB_DATA (MSB_DATA),
    .MSB_ROM  (MSB_ROM),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk   (CLOCK_i),
    .rst   (RESET_i),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (commit_addr_s),
    .wdata (commit_data_s),
    .rdata (DATA_dm_o)
  );

  assign HOLD_n_o = hold_n_r;
  assign ERROR_o  = error_r;

endmodule

// File: tb/tb_data_memory_16bits.sv
// Self-checking bench: four responders with different wait-state / depth
// settings, checked against a word-array model of the memory bus.
module tb_data_memory_16bits;

  localparam int ND = 4;
  localparam int K_READ = 0, K_WRITE = 1, K_WRITE_OE = 2;

  logic        clk;
  logic [3:0]  rst, ce_n, oe_n, we_n, hold_n, err;
  logic [10:0] addr  [ND];
  logic [15:0] wdata [ND];
  logic [15:0] rdata [ND];

  // Reference model state
  int          ws_m    [ND] = '{1, 3, 0, 2};
  int          depth_m [ND] = '{2048, 2048, 2048, 1024};
  logic [15:0] mem_m   [ND][2048];
  logic [15:0] last_rd_m [ND];
  bit          err_m   [ND];

  int checks = 0;
  int failures = 0;

  data_memory_16bits #(.WAIT_STATES(1), .DEPTH(2048)) u_d0 (
    .CLOCK_i(clk), .RESET_i(rst[0]), .CEnable_dm_i(ce_n[0]), .OEnable_dm_i(oe_n[0]),
    .WEnable_dm_i(we_n[0]), .ADDR_dm_i(addr[0]), .DATA_dm_i(wdata[0]),
    .DATA_dm_o(rdata[0]), .HOLD_n_o(hold_n[0]), .ERROR_o(err[0]));
  data_memory_16bits #(.WAIT_STATES(3), .DEPTH(2048)) u_d1 (
    .CLOCK_i(clk), .RESET_i(rst[1]), .CEnable_dm_i(ce_n[1]), .OEnable_dm_i(oe_n[1]),
    .WEnable_dm_i(we_n[1]), .ADDR_dm_i(addr[1]), .DATA_dm_i(wdata[1]),
    .DATA_dm_o(rdata[1]), .HOLD_n_o(hold_n[1]), .ERROR_o(err[1]));
  data_memory_16bits #(.WAIT_STATES(0), .DEPTH(2048)) u_d2 (
    .CLOCK_i(clk), .RESET_i(rst[2]), .CEnable_dm_i(ce_n[2]), .OEnable_dm_i(oe_n[2]),
    .WEnable_dm_i(we_n[2]), .ADDR_dm_i(addr[2]), .DATA_dm_i(wdata[2]),
    .DATA_dm_o(rdata[2]), .HOLD_n_o(hold_n[2]), .ERROR_o(err[2]));
  data_memory_16bits #(.WAIT_STATES(2), .DEPTH(1024)) u_d3 (
    .CLOCK_i(clk), .RESET_i(rst[3]), .CEnable_dm_i(ce_n[3]), .OEnable_dm_i(oe_n[3]),
    .WEnable_dm_i(we_n[3]), .ADDR_dm_i(addr[3]), .DATA_dm_i(wdata[3]),
    .DATA_dm_o(rdata[3]), .HOLD_n_o(hold_n[3]), .ERROR_o(err[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model of one completed bus access.
  task automatic model_access(input int d, input int kind, input logic [10:0] a,
                              input logic [15:0] wd);
    if (kind == K_READ) begin
      last_rd_m[d] = (int'(a) < depth_m[d]) ? mem_m[d][a] : 16'h0000;
    end else if (int'(a) < depth_m[d]) begin
      mem_m[d][a] = wd;
    end
    if (int'(a) >= depth_m[d] || kind == K_WRITE_OE) err_m[d] = 1'b1;
  endtask

  // One isolated access: present for one edge, then count hold cycles.
  task automatic do_access(input int d, input int kind, input logic [10:0] a,
                           input logic [15:0] wd, input bit scramble, input string name);
    int hold_cnt;
    ce_n[d] = 1'b0;
    we_n[d] = (kind == K_READ);
    oe_n[d] = (kind == K_WRITE);
    addr[d] = a;
    wdata[d] = wd;
    tick();
    ce_n[d] = 1'b1; we_n[d] = 1'b1; oe_n[d] = 1'b1;
    if (scramble) begin
      addr[d]  = 11'h7FF;
      wdata[d] = 16'($urandom);
    end
    hold_cnt = 0;
    while (hold_n[d] === 1'b0 && hold_cnt < 16) begin
      hold_cnt++;
      tick();
    end
    model_access(d, kind, a, wd);
    checks++;
    if (hold_cnt !== ws_m[d]) begin
      failures++;
      $display("FAIL %s hold_cycles d%0d: got %0d expected %0d", name, d, hold_cnt, ws_m[d]);
    end
    checks++;
    if (rdata[d] !== last_rd_m[d]) begin
      failures++;
      $display("FAIL %s rdata d%0d addr=%h: got %h expected %h", name, d, a, rdata[d], last_rd_m[d]);
    end
    checks++;
    if (err[d] !== err_m[d]) begin
      failures++;
      $display("FAIL %s error d%0d: got %b expected %b", name, d, err[d], err_m[d]);
    end
  endtask

  task automatic check_idle_outputs(input int d, input string name);
    checks++;
    if (rdata[d] !== 16'h0000 || hold_n[d] !== 1'b1 || err[d] !== 1'b0) begin
      failures++;
      $display("FAIL %s d%0d: got data=%h hold_n=%b err=%b expected 0000/1/0",
               name, d, rdata[d], hold_n[d], err[d]);
    end
  endtask

  task automatic reset_one(input int d);
    rst[d] = 1'b1;
    tick();
    rst[d] = 1'b0;
    err_m[d] = 1'b0;
    last_rd_m[d] = 16'h0000;
  endtask

  task automatic test_reset;
    rst = 4'hF; ce_n = 4'hF; oe_n = 4'hF; we_n = 4'hF;
    for (int d = 0; d < ND; d++) begin
      addr[d] = 11'h000; wdata[d] = 16'h0000; last_rd_m[d] = 16'h0000; err_m[d] = 1'b0;
    end
    tick();
    for (int d = 0; d < ND; d++) check_idle_outputs(d, "reset");
    tick();
    rst = 4'h0;
    tick();
    for (int d = 0; d < ND; d++) check_idle_outputs(d, "after_reset");
  endtask

  task automatic test_write_read;
    do_access(0, K_WRITE, 11'h123, 16'hBEEF, 1'b0, "wr_beef");
    do_access(0, K_READ,  11'h123, 16'h0000, 1'b0, "rd_beef");
  endtask

  task automatic test_wait3_capture;
    do_access(1, K_WRITE, 11'h000, 16'h0001, 1'b1, "ws3_wr");
    do_access(1, K_READ,  11'h000, 16'h0000, 1'b1, "ws3_rd");
    do_access(1, K_READ,  11'h000, 16'h0000, 1'b0, "ws3_rd2");
  endtask

  task automatic test_back_to_back;
    int          kinds [6] = '{K_WRITE, K_WRITE, K_READ, K_READ, K_WRITE, K_READ};
    logic [10:0] addrs [6] = '{11'h010, 11'h011, 11'h010, 11'h011, 11'h010, 11'h010};
    logic [15:0] datas [6] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h3333, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      ce_n[2] = 1'b0;
      we_n[2] = (kinds[i] == K_READ);
      oe_n[2] = (kinds[i] != K_READ);
      addr[2] = addrs[i];
      wdata[2] = datas[i];
      tick();
      model_access(2, kinds[i], addrs[i], datas[i]);
      checks++;
      if (hold_n[2] !== 1'b1 || rdata[2] !== last_rd_m[2]) begin
        failures++;
        $display("FAIL b2b step%0d: got hold_n=%b data=%h expected 1/%h",
                 i, hold_n[2], rdata[2], last_rd_m[2]);
      end
    end
    ce_n[2] = 1'b1; we_n[2] = 1'b1; oe_n[2] = 1'b1;
    tick();
  endtask

  task automatic test_illegal_combo;
    do_access(0, K_WRITE_OE, 11'h020, 16'h5A5A, 1'b0, "illegal_wr");
    do_access(0, K_READ,     11'h020, 16'h0000, 1'b0, "illegal_rd");
    do_access(0, K_WRITE,    11'h021, 16'h0F0F, 1'b0, "sticky_wr");
    reset_one(0);
    check_idle_outputs(0, "err_cleared");
    do_access(0, K_READ,     11'h020, 16'h0000, 1'b0, "array_kept");
  endtask

  task automatic test_out_of_range;
    do_access(3, K_WRITE, 11'h000, 16'hA000, 1'b0, "oor_pre0");
    do_access(3, K_WRITE, 11'h3FF, 16'hA3FF, 1'b0, "oor_pre3ff");
    do_access(3, K_READ,  11'h3FF, 16'h0000, 1'b0, "edge_rd3ff");
    do_access(3, K_READ,  11'h400, 16'h0000, 1'b0, "oor_rd400");
    do_access(3, K_WRITE, 11'h400, 16'hDEAD, 1'b0, "oor_wr400");
    do_access(3, K_READ,  11'h000, 16'h0000, 1'b0, "oor_alias0");
  endtask

  task automatic test_reset_mid_wait;
    reset_one(3);
    do_access(3, K_WRITE, 11'h005, 16'h1234, 1'b0, "mid_pre");
    ce_n[3] = 1'b0; we_n[3] = 1'b0; oe_n[3] = 1'b1;
    addr[3] = 11'h005; wdata[3] = 16'hDEAD;
    tick();
    ce_n[3] = 1'b1; we_n[3] = 1'b1;
    checks++;
    if (hold_n[3] !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_hold: got %b expected 0", hold_n[3]);
    end
    reset_one(3);
    check_idle_outputs(3, "mid_wait_abort");
    do_access(3, K_READ, 11'h005, 16'h0000, 1'b0, "mid_old_value");
  endtask

  task automatic test_random;
    logic [10:0] pool [8];
    logic [10:0] a;
    int          kind;
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < 8; p++) begin
        pool[p] = 11'($urandom_range(0, depth_m[d] - 1));
        do_access(d, K_WRITE, pool[p], 16'($urandom), 1'b0, "rnd_init");
      end
      for (int n = 0; n < 25; n++) begin
        kind = int'($urandom_range(0, 1));
        a = pool[$urandom_range(0, 7)];
        if (d == 3 && $urandom_range(0, 4) == 0) a = 11'($urandom_range(1024, 2047));
        do_access(d, kind, a, 16'($urandom), ($urandom_range(0, 1) == 1), "rnd");
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait3_capture();
    test_back_to_back();
    test_illegal_combo();
    test_out_of_range();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
